// File: rtl/seq_divider.sv
// Multi-cycle restoring radix-2 integer divider, one quotient bit per clock.
// Result is packed as {quotient, remainder}; signed and unsigned operands.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] qr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]   bmag, bmag_nxt;
  logic [WIDTH-1:0]   a_raw, a_raw_nxt;
  logic               neg_q, neg_q_nxt;
  logic               neg_r, neg_r_nxt;
  logic               dz, dz_nxt;
  logic               busy_nxt, done_nxt, div_zero_nxt;
  logic [2*WIDTH-1:0] qr_nxt;

  // WIDTH+1-bit shifted remainder so the compare against |b| cannot overflow
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub, quo_sh, q_fin, r_fin, a_mag, b_mag;
  logic               rem_ge;

  // Datapath helpers: operand magnitudes, shift/subtract step, sign fix-up
  always_comb begin
    a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + ONE) : a;
    b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + ONE) : b;
    rem_sh  = {rem, quo[WIDTH-1]};
    quo_sh  = {quo[WIDTH-2:0], 1'b0};
    rem_ge  = (rem_sh >= {1'b0, bmag});
    rem_sub = rem_sh[WIDTH-1:0] - bmag;
    q_fin   = neg_q ? (~quo + ONE) : quo;
    r_fin   = neg_r ? (~rem + ONE) : rem;
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rem_nxt      = rem;
    quo_nxt      = quo;
    bmag_nxt     = bmag;
    a_raw_nxt    = a_raw;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    dz_nxt       = dz;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    div_zero_nxt = div_zero;
    qr_nxt       = qr;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt      = '0;
          rem_nxt      = '0;
          quo_nxt      = a_mag;
          bmag_nxt     = b_mag;
          a_raw_nxt    = a;
          neg_q_nxt    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_nxt    = signed_mode & a[WIDTH-1];
          dz_nxt       = (b == '0);
          busy_nxt     = 1'b1;
          div_zero_nxt = 1'b0;
          state_nxt    = (b == '0) ? FINISH : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (rem_ge) begin
          rem_nxt = rem_sub;
          quo_nxt = {quo_sh[WIDTH-1:1], 1'b1};
        end else begin
          rem_nxt = rem_sh[WIDTH-1:0];
          quo_nxt = quo_sh;
        end
        if (cnt == CNT_LAST) begin
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      FINISH: begin
        qr_nxt       = dz ? {{WIDTH{1'b1}}, a_raw} : {q_fin, r_fin};
        div_zero_nxt = dz;
        done_nxt     = 1'b1;
        busy_nxt     = 1'b0;
        state_nxt    = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      bmag     <= '0;
      a_raw    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      qr       <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      quo      <= quo_nxt;
      bmag     <= bmag_nxt;
      a_raw    <= a_raw_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      dz       <= dz_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
      qr       <= qr_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        busy, done, div_zero;
  logic [31:0] qr;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .qr(qr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: truncating division using plain integer arithmetic
  function automatic logic [31:0] ref_qr(input logic [15:0] ra, input logic [15:0] rb, input logic sm);
    int sa, sb, q, r;
    logic [15:0] uq, ur;
    if (rb == 16'd0) return {16'hFFFF, ra};
    if (sm) begin
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      q  = sa / sb;
      r  = sa % sb;
      return {q[15:0], r[15:0]};
    end
    uq = ra / rb;
    ur = ra % rb;
    return {uq, ur};
  endfunction

  // Starts an op from the current time (just after an edge) and checks result/latency.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic sm, input bit disturb);
    logic [31:0] exp;
    int lat, n;
    exp = ref_qr(ta, tb_v, sm);
    lat = (tb_v == 16'd0) ? 1 : 17;
    a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, ".busy_on"}, {31'd0, busy}, 32'd1);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    n = 0;
    while (n < 40) begin
      n++;
      @(posedge clk); #1;
      if (done) break;
      if (disturb && (n == 3 || n == 10)) begin
        start = 1'b1; a = 16'($urandom_range(1, 65535)); b = 16'($urandom_range(1, 65535));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, ".latency"}, n, lat);
    check_eq({tag, ".qr"}, qr, exp);
    check_eq({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, (tb_v == 16'd0)});
    check_eq({tag, ".busy_off"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt_done;
    logic [15:0] ra, rb;
    logic rs;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.busy", {31'd0, busy}, 32'd0);
    check_eq("rst.done", {31'd0, done}, 32'd0);
    check_eq("rst.dz", {31'd0, div_zero}, 32'd0);
    check_eq("rst.qr", qr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("u100_7", 16'd100, 16'd7, 1'b0, 1'b0);
    check_eq("u100_7.const", qr, 32'h000E0002);
    @(posedge clk); #1;
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    run_op("u3_10", 16'd3, 16'd10, 1'b0, 1'b0);
    check_eq("u3_10.const", qr, 32'h00000003);
    run_op("s-100_7", 16'hFF9C, 16'd7, 1'b1, 1'b0);
    check_eq("s-100_7.const", qr, 32'hFFF2FFFE);
    run_op("s100_-7", 16'd100, 16'hFFF9, 1'b1, 1'b0);
    check_eq("s100_-7.const", qr, 32'hFFF20002);
    run_op("dz", 16'h1234, 16'h0000, 1'b0, 1'b0);
    check_eq("dz.const", qr, 32'hFFFF1234);
    check_eq("dz.flag_hold", {31'd0, div_zero}, 32'd1);
    run_op("after_dz", 16'd50, 16'd5, 1'b0, 1'b0);
    run_op("s_ovf", 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    check_eq("s_ovf.const", qr, 32'h80000000);
    run_op("uFFFF_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check_eq("uFFFF_1.const", qr, 32'hFFFF0000);
    run_op("uFFFF_FFFF", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check_eq("uFFFF_FFFF.const", qr, 32'h00010000);

    // Ignored starts while busy; then back-to-back start in the done cycle
    run_op("disturb", 16'd100, 16'd7, 1'b0, 1'b1);
    check_eq("disturb.const", qr, 32'h000E0002);
    run_op("b2b", 16'd1000, 16'd33, 1'b0, 1'b0);

    // Reset in the middle of an operation
    a = 16'd100; b = 16'd7; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst.busy", {31'd0, busy}, 32'd0);
    check_eq("midrst.done", {31'd0, done}, 32'd0);
    check_eq("midrst.qr", qr, 32'd0);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    check_eq("midrst.no_done", cnt_done, 32'd0);
    run_op("post_rst", 16'd777, 16'd9, 1'b0, 1'b0);

    // Random operands, both modes, occasional zero divisor
    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 20));
      rs = 1'($urandom);
      run_op($sformatf("rnd%0d", k), ra, rb, rs, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
